// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5 key-expansion arbiter.
package rc5_pkg;

  localparam int unsigned KEY_BITS = 128;
  localparam int unsigned ROUNDS_W = 5;
  localparam int unsigned W_SIZE   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } kga_state_t;

  // Worst-case engine latency: setup + L load + S init + 3*max(T,c) mixing + handoff.
  function automatic int unsigned max_keygen_cycles(input logic [ROUNDS_W-1:0] rounds);
    int unsigned t;
    t = 2 * (int'(rounds) + 1);
    return 1 + 16 + t + 3 * t + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  always_comb begin
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/keygen_arbiter.sv
// Round-robin sharing of one RC5 key-expansion engine between NUM_REQ requesters.
// Optional result cache (skips the engine on a repeated key) under RC5_KEYGEN_CACHE_EN.
module keygen_arbiter
  import rc5_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][KEY_BITS-1:0]   req_key,
  input  logic [NUM_REQ-1:0][ROUNDS_W-1:0]   req_rounds,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 done,
  output logic                               err,
  output logic                               busy,
  output logic                               kg_start,
  output logic [KEY_BITS-1:0]                kg_key,
  output logic [ROUNDS_W-1:0]                kg_rounds,
  input  logic                               kg_ready
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  kga_state_t         state;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic               err_flag;
  logic [NUM_REQ-1:0] arb_winner;
  logic               arb_valid;
  logic [PTR_W-1:0]   arb_idx;
  logic               cache_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_winner[i]) arb_idx = PTR_W'(i);
    end
  end

`ifdef RC5_KEYGEN_CACHE_EN
  logic [KEY_BITS-1:0] last_key;
  logic [ROUNDS_W-1:0] last_rounds;
  logic                cache_valid;

  assign cache_hit = cache_valid && (kg_key == last_key) && (kg_rounds == last_rounds);
`else
  assign cache_hit = 1'b0;
`endif

  // Grant/done decode depends only on state and the latched winner, never on req.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state != IDLE) gnt[win_idx] = 1'b1;
    if (state == DONE) done[win_idx] = 1'b1;
  end

  assign busy     = (state != IDLE);
  assign kg_start = (state == ISSUE) && !cache_hit;
  assign err      = (state == DONE) && err_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      win_idx     <= '0;
      rr_ptr      <= '0;
      cnt         <= '0;
      err_flag    <= 1'b0;
      kg_key      <= '0;
      kg_rounds   <= '0;
`ifdef RC5_KEYGEN_CACHE_EN
      last_key    <= '0;
      last_rounds <= '0;
      cache_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            win_idx   <= arb_idx;
            kg_key    <= req_key[arb_idx];
            kg_rounds <= req_rounds[arb_idx];
            rr_ptr    <= (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_W'(1);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= cache_hit ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // Ready takes priority over a coincident timeout.
          if (kg_ready) begin
            state <= DONE;
`ifdef RC5_KEYGEN_CACHE_EN
            last_key    <= kg_key;
            last_rounds <= kg_rounds;
            cache_valid <= 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state    <= DONE;
            err_flag <= 1'b1;
`ifdef RC5_KEYGEN_CACHE_EN
            cache_valid <= 1'b0;
`endif
          end
        end
        DONE: begin
          cnt      <= '0;
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keygen_arbiter.sv
// Directed bench for keygen_arbiter: a default-timeout instance with an engine model,
// plus a TIMEOUT_CYCLES=16 instance driven by hand for timeout boundaries.
module tb_keygen_arbiter;
  import rc5_pkg::*;

  localparam int N = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [N-1:0]                 req;
  logic [N-1:0][KEY_BITS-1:0]   req_key;
  logic [N-1:0][ROUNDS_W-1:0]   req_rounds;
  logic [N-1:0]                 gnt, done;
  logic                         err, busy, kg_start, kg_ready;
  logic [KEY_BITS-1:0]          kg_key;
  logic [ROUNDS_W-1:0]          kg_rounds;

  logic [N-1:0]                 t_req;
  logic [N-1:0][KEY_BITS-1:0]   t_req_key;
  logic [N-1:0][ROUNDS_W-1:0]   t_req_rounds;
  logic [N-1:0]                 t_gnt, t_done;
  logic                         t_err, t_busy, t_kg_start, t_kg_ready;
  logic [KEY_BITS-1:0]          t_kg_key;
  logic [ROUNDS_W-1:0]          t_kg_rounds;

  int errors = 0;
  int checks = 0;
  int ready_delay = 0;
  int start_cnt = 0;
  int eng_cnt;
  int done_cnt [N];
  int dc0 [N];
  int s0, n;

  always #5 clk = ~clk;

  keygen_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (512)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_key    (req_key),
    .req_rounds (req_rounds),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .kg_start   (kg_start),
    .kg_key     (kg_key),
    .kg_rounds  (kg_rounds),
    .kg_ready   (kg_ready)
  );

  keygen_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (16)
  ) dut_to (
    .clk        (clk),
    .rst        (rst),
    .req        (t_req),
    .req_key    (t_req_key),
    .req_rounds (t_req_rounds),
    .gnt        (t_gnt),
    .done       (t_done),
    .err        (t_err),
    .busy       (t_busy),
    .kg_start   (t_kg_start),
    .kg_key     (t_kg_key),
    .kg_rounds  (t_kg_rounds),
    .kg_ready   (t_kg_ready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done == '0 && cycles < budget) begin
      tick();
      cycles++;
    end
    check("done_seen", done != '0, 1);
  endtask

  // Engine model: ready_delay cycles after the start cycle it pulses kg_ready (0 = never).
  initial begin
    kg_ready = 1'b0;
    eng_cnt  = -1;
    foreach (done_cnt[i]) done_cnt[i] = 0;
    forever begin
      @(negedge clk);
      kg_ready = 1'b0;
      if (rst) begin
        eng_cnt = -1;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            kg_ready = 1'b1;
            eng_cnt  = -1;
          end
        end
        if (kg_start) begin
          start_cnt++;
          eng_cnt = (ready_delay > 0) ? ready_delay : -1;
        end
        for (int i = 0; i < N; i++) if (done[i]) done_cnt[i]++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    req          = '0;
    req_key      = '0;
    req_rounds   = '0;
    t_req        = '0;
    t_req_key    = '0;
    t_req_rounds = '0;
    t_kg_ready   = 1'b0;
    req_key[0]   = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    req_rounds[0] = 5'd5;
    req_key[1]   = 128'h11111111_22222222_33333333_44444444;
    req_rounds[1] = 5'd8;

    repeat (2) tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_start", kg_start, 0);
    check("rst_key", kg_key, 0);
    check("rst_rounds", kg_rounds, 0);
    rst = 1'b0;
    tick();

    // Single request: ready 200 cycles after start, done one cycle later.
    req_key[2]    = 128'h000102030405060708090a0b0c0d0e0f;
    req_rounds[2] = 5'd12;
    ready_delay   = 200;
    s0            = start_cnt;
    req           = 4'b0100;
    tick();
    check("t1_gnt", gnt, 4'b0100);
    check("t1_start", kg_start, 1);
    check("t1_key", kg_key, 128'h000102030405060708090a0b0c0d0e0f);
    check("t1_rounds", kg_rounds, 12);
    check("t1_busy", busy, 1);
    wait_done(300, n);
    check("t1_latency", n, 201);
    check("t1_done", done, 4'b0100);
    check("t1_err", err, 0);
    check("t1_nstart", start_cnt - s0, 1);
    req = '0;
    tick();
    check("t1_idle_gnt", gnt, 0);
    check("t1_idle_busy", busy, 0);

    // Contention from rr_ptr=0: order 0,1,2,3,0 with one IDLE cycle between grants.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_delay = 3;
    s0 = start_cnt;
    foreach (dc0[i]) dc0[i] = done_cnt[i];
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] exp_g;
      int k;
      exp_g = '0;
      exp_g[g % N] = 1'b1;
      k = 0;
      do begin
        tick();
        k++;
      end while (gnt == '0 && k < 5);
      check("t2_gnt", gnt, exp_g);
      check("t2_start", kg_start, 1);
      wait_done(20, n);
      check("t2_done", done, exp_g);
      tick();
      check("t2_gap_busy", busy, 0);
    end
    req = '0;
    tick();
    check("t2_nstart", start_cnt - s0, 5);
    check("t2_dcnt0", done_cnt[0] - dc0[0], 2);
    for (int i = 1; i < N; i++) check("t2_dcnt", done_cnt[i] - dc0[i], 1);

    // Request withdrawn one cycle after grant still completes.
    req = 4'b0001;
    tick();
    check("t3_gnt", gnt, 4'b0001);
    req = '0;
    wait_done(20, n);
    check("t3_done", done, 4'b0001);
    check("t3_err", err, 0);
    tick();

    // Async reset mid-WAIT clears outputs before the next edge.
    ready_delay = 0;
    req = 4'b0001;
    repeat (3) tick();
    check("t4_busy_pre", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t4_gnt", gnt, 0);
    check("t4_busy", busy, 0);
    check("t4_start", kg_start, 0);
    check("t4_done", done, 0);
    check("t4_key", kg_key, 0);
    tick();
    req = 4'b0010;
    ready_delay = 4;
    rst = 1'b0;
    s0 = start_cnt;
    tick();
    check("t4_regnt", gnt, 4'b0010);
    check("t4_restart", kg_start, 1);
    wait_done(20, n);
    check("t4_redone", done, 4'b0010);
    check("t4_nstart", start_cnt - s0, 1);
    req = '0;
    tick();

    // Timeout on the TIMEOUT_CYCLES=16 instance: start cycle + 16 WAIT cycles, then DONE.
    t_req_key[3] = 128'h0f0e0d0c0b0a09080706050403020100;
    t_req = 4'b1000;
    tick();
    check("t5_gnt", t_gnt, 4'b1000);
    check("t5_start", t_kg_start, 1);
    n = 0;
    while (t_done == '0 && n < 40) begin
      tick();
      n++;
    end
    check("t5_latency", n, 17);
    check("t5_done", t_done, 4'b1000);
    check("t5_err", t_err, 1);
    t_req = '0;
    tick();
    check("t5_err_clr", t_err, 0);
    check("t5_idle", t_busy, 0);

    t_req = 4'b0001;
    tick();
    check("t5b_start", t_kg_start, 1);
    tick();
    t_kg_ready = 1'b1;
    tick();
    t_kg_ready = 1'b0;
    check("t5b_done", t_done, 4'b0001);
    check("t5b_err", t_err, 0);
    t_req = '0;
    tick();

    // Ready in the same cycle the counter reaches its limit: ready wins.
    t_req = 4'b0100;
    tick();
    repeat (16) tick();
    check("t6_not_yet", t_done, 0);
    t_kg_ready = 1'b1;
    tick();
    t_kg_ready = 1'b0;
    check("t6_done", t_done, 4'b0100);
    check("t6_err", t_err, 0);
    t_req = '0;
    tick();

    // Repeated identical key, then changed rounds.
    ready_delay   = 3;
    req_key[3]    = 128'h5a5a5a5a_a5a5a5a5_00ff00ff_ff00ff00;
    req_rounds[3] = 5'd12;
    req = 4'b1000;
    tick();
    check("t7_start1", kg_start, 1);
    wait_done(20, n);
    req = '0;
    tick();
    req = 4'b1000;
    tick();
`ifdef RC5_KEYGEN_CACHE_EN
    check("t7_start2", kg_start, 0);
    tick();
    check("t7_done2", done, 4'b1000);
`else
    check("t7_start2", kg_start, 1);
    wait_done(20, n);
    check("t7_done2", done, 4'b1000);
`endif
    req = '0;
    tick();
    req_rounds[3] = 5'd13;
    req = 4'b1000;
    tick();
    check("t7_start3", kg_start, 1);
    wait_done(20, n);
    check("t7_done3", done, 4'b1000);
    req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keygen_arbiter.md
Name: keygen_arbiter

Overview:
- Shares the single RC5 key-expansion engine between NUM_REQ requesters, e.g. encrypt and decrypt pipelines or multiple host channels.
- Picks one requester round-robin and latches its key and round count.
- Drives the engine's start pulse, waits for its one-cycle ready, then returns a done pulse to the winner. While the winner holds gnt it may read the engine's subkey array.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 512, cycles allowed in WAIT before abort. Must exceed the worst-case expansion time of about 280 cycles at 31 rounds.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester request level
- req_key  in  NUM_REQ x 128  per-requester key
- req_rounds  in  NUM_REQ x 5  per-requester round count
- gnt  out  NUM_REQ  one-hot grant; subkeys are valid for the holder while high
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  one-cycle pulse alongside done when the engine timed out
- busy  out  1  high in any state other than IDLE
- kg_start  out  1  start pulse to the key-expansion engine
- kg_key  out  128  registered key to the engine
- kg_rounds  out  5  registered round count to the engine
- kg_ready  in  1  engine ready pulse (one cycle)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: gnt=0, done=0, err=0, busy=0, kg_start=0, kg_key=0, kg_rounds=0, rr_ptr=0, state=IDLE, timeout counter=0.
- Reset mid-operation aborts with no done pulse. kg_start is held low so the engine idles.
- States:
  - IDLE -> ISSUE when any req bit is high. The winner is the first set bit searching upward from rr_ptr, wrapping. On this edge: gnt[winner]<=1, kg_key/kg_rounds <= winner's inputs, rr_ptr <= winner+1 mod NUM_REQ.
  - ISSUE: kg_start=1 for exactly this one cycle; -> WAIT.
  - WAIT: counter increments each cycle. kg_ready=1 -> DONE. Else if counter==TIMEOUT_CYCLES-1 -> DONE with err_flag set. If ready and the timeout coincide, ready wins and err_flag is not set.
  - DONE: done[winner]=1 and err=err_flag for this one cycle; gnt cleared on exit; counter and err_flag cleared; -> IDLE.
- Latency: req sampled at edge N gives gnt high after edge N; kg_start in cycle N+1; done in the cycle after kg_ready is seen. Minimum re-arbitration gap is one IDLE cycle.
- Handshake:
  - Requesters hold req and stable inputs until done.
  - Key and rounds are latched at grant, so later input changes have no effect.
  - Dropping req while granted does not abort; done still pulses to the winner.
  - req high in the done cycle is eligible in the next IDLE.
- Fairness: a requester that reasserts immediately after its done is served after every other pending requester.
- gnt and done are combinational functions of state and winner index only, never of req.

Optional Feature:
- Macro: RC5_KEYGEN_CACHE_EN.
- When defined:
  - Registers last_key, last_rounds and cache_valid; all reset to 0.
  - In ISSUE, if cache_valid and the latched key/rounds equal last_key/last_rounds, kg_start is suppressed and the FSM goes straight to DONE. done then arrives two cycles after the grant edge.
  - A successful engine run sets cache_valid and stores the key/rounds.
  - A timeout clears cache_valid.
- When undefined: every grant pulses kg_start, and no cache registers exist.

Decomposition:
- rc5_pkg holds:
  - KEY_BITS=128, ROUNDS_W=5, W_SIZE=16.
  - Enum kga_state_t {IDLE, ISSUE, WAIT, DONE}.
  - Function max_keygen_cycles(rounds) returning 1+16+T+3T+1, with T=2(rounds+1).
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin pick. Inputs req and rr_ptr; outputs a one-hot winner and a valid flag.

Test Plan:
- Single request: req[2]=1, key=0x00..0F, rounds=12; engine model returns ready 200 cycles after start → gnt[2] high, exactly one kg_start, kg_key=0x00..0F, done[2] one cycle after ready, err=0.
- Contention: req=4'b1111 held with rr_ptr=0 → grants in order 0,1,2,3,0. Each gets exactly one done. busy stays high except for one IDLE cycle per grant.
- Timeout: engine never asserts ready, TIMEOUT_CYCLES=16 → done with err=1 exactly 16 WAIT cycles after start. The next request is served normally.
- Async reset asserted mid-WAIT → all outputs 0 immediately, before the next clk edge. After release with req[1]=1 → gnt[1] and a fresh kg_start.
- Request withdrawn: req[0] dropped one cycle after grant → transaction completes and done[0] still pulses.
- With RC5_KEYGEN_CACHE_EN: two consecutive requests with an identical key and rounds=12 → second produces no kg_start and done two cycles after grant. Changing to rounds=13 produces kg_start again.
